serialize_stream: RTL and testbench

//   Single-clock parametrised serializer with valid/ready handshakes on both sides.

---
 rtl/serialize_stream_if.sv | 25 ++
 rtl/serialize_stream.sv | 96 +++++++++
 tb/tb_serialize_stream.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serialize_stream_if.sv
// Handshake bundle for serialize_stream: wide word in, narrow chunks out.
// The slave modport is the serializer's view; master is the view of whatever drives it.
interface serialize_stream_if #(
    parameter int DATA_WIDTH = 128,
    parameter int OUT_WIDTH  = 32
);
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_valid;
    logic                  o_ready;
    logic [OUT_WIDTH-1:0]  o_data;
    logic                  o_valid;
    logic                  i_ready;
    logic                  o_first;
    logic                  o_last;

    modport slave (
        input  i_data, i_valid, i_ready,
        output o_ready, o_data, o_valid, o_first, o_last
    );

    modport master (
        output i_data, i_valid, i_ready,
        input  o_ready, o_data, o_valid, o_first, o_last
    );
endinterface

// File: rtl/serialize_stream.sv
// Wide-to-narrow serializer: each accepted DATA_WIDTH word leaves as DIVIDE_NUM
// sequential chunks with first/last markers; downstream stalls back-pressure the input.
module serialize_stream #(
    parameter int DATA_WIDTH = 128,
    parameter int DIVIDE_NUM = 4,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    serialize_stream_if.slave  bus
);
    localparam int OUT_WIDTH = DATA_WIDTH / DIVIDE_NUM;
    localparam int CNT_WIDTH = $clog2(DIVIDE_NUM + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DIVIDE_NUM - 1);

    generate
        if (DIVIDE_NUM < 1 || (DATA_WIDTH % DIVIDE_NUM) != 0) begin : g_bad_params
            $error("serialize_stream: DATA_WIDTH must be a positive multiple of DIVIDE_NUM");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] sreg_reg, sreg_next;
    logic [DATA_WIDTH-1:0] sreg_shifted;
    logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
    logic                  valid_reg, valid_next;
    logic [OUT_WIDTH-1:0]  chunk [DIVIDE_NUM];
    logic                  last;
    logic                  ready;
    logic                  in_fire;
    logic                  out_fire;

    // The output slot is chunk 0 (LSB-first) or the top chunk (MSB-first); each
    // advance moves every chunk one slot toward it and zero-fills the far end.
    genvar gi;
    generate
        for (gi = 0; gi < DIVIDE_NUM; gi++) begin : g_chunk
            assign chunk[gi] = sreg_reg[gi*OUT_WIDTH +: OUT_WIDTH];
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_fill
                    assign sreg_shifted[gi*OUT_WIDTH +: OUT_WIDTH] = '0;
                end else begin : g_move
                    assign sreg_shifted[gi*OUT_WIDTH +: OUT_WIDTH] = chunk[gi-1];
                end
            end else begin : g_lsb
                if (gi == DIVIDE_NUM - 1) begin : g_fill
                    assign sreg_shifted[gi*OUT_WIDTH +: OUT_WIDTH] = '0;
                end else begin : g_move
                    assign sreg_shifted[gi*OUT_WIDTH +: OUT_WIDTH] = chunk[gi+1];
                end
            end
        end
    endgenerate

    assign last     = valid_reg && (cnt_reg == LAST_CNT);
    assign ready    = !valid_reg || (bus.i_ready && last);
    assign in_fire  = bus.i_valid && ready;
    assign out_fire = valid_reg && bus.i_ready;

    // A load can only coincide with the final chunk leaving, so it takes priority.
    always_comb begin
        sreg_next  = sreg_reg;
        cnt_next   = cnt_reg;
        valid_next = valid_reg;
        if (in_fire) begin
            sreg_next  = bus.i_data;
            cnt_next   = '0;
            valid_next = 1'b1;
        end else if (out_fire) begin
            if (last) begin
                cnt_next   = '0;
                valid_next = 1'b0;
            end else begin
                cnt_next  = cnt_reg + CNT_WIDTH'(1);
                sreg_next = sreg_shifted;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sreg_reg  <= '0;
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            sreg_reg  <= sreg_next;
            cnt_reg   <= cnt_next;
            valid_reg <= valid_next;
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_valid = valid_reg;
    assign bus.o_data  = MSB_FIRST ? chunk[DIVIDE_NUM-1] : chunk[0];
    assign bus.o_first = valid_reg && (cnt_reg == '0);
    assign bus.o_last  = last;
endmodule

// File: tb/tb_serialize_stream.sv
// Bench for serialize_stream: directed word sequences on 32-bit LSB/MSB-first instances,
// then random traffic on 128/4 and 32/1 instances, all tracked by a chunk scoreboard.
module tb_serialize_stream;
    logic clk;
    logic rst;

    logic [31:0]  a_data;
    logic         a_valid, a_ready;
    logic [127:0] c_data;
    logic         c_valid, c_ready;
    logic [31:0]  d_data;
    logic         d_valid, d_ready;

    int checks = 0;
    int errors = 0;

    serialize_stream_if #(.DATA_WIDTH(32),  .OUT_WIDTH(8))  bus_a ();
    serialize_stream_if #(.DATA_WIDTH(32),  .OUT_WIDTH(8))  bus_b ();
    serialize_stream_if #(.DATA_WIDTH(128), .OUT_WIDTH(32)) bus_c ();
    serialize_stream_if #(.DATA_WIDTH(32),  .OUT_WIDTH(32)) bus_d ();

    assign bus_a.i_data = a_data;  assign bus_a.i_valid = a_valid;  assign bus_a.i_ready = a_ready;
    assign bus_b.i_data = a_data;  assign bus_b.i_valid = a_valid;  assign bus_b.i_ready = a_ready;
    assign bus_c.i_data = c_data;  assign bus_c.i_valid = c_valid;  assign bus_c.i_ready = c_ready;
    assign bus_d.i_data = d_data;  assign bus_d.i_valid = d_valid;  assign bus_d.i_ready = d_ready;

    serialize_stream #(.DATA_WIDTH(32),  .DIVIDE_NUM(4), .MSB_FIRST(1'b0)) dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a));
    serialize_stream #(.DATA_WIDTH(32),  .DIVIDE_NUM(4), .MSB_FIRST(1'b1)) dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b));
    serialize_stream #(.DATA_WIDTH(128), .DIVIDE_NUM(4), .MSB_FIRST(1'b0)) dut_c (.i_clk(clk), .i_rst(rst), .bus(bus_c));
    serialize_stream #(.DATA_WIDTH(32),  .DIVIDE_NUM(1), .MSB_FIRST(1'b0)) dut_d (.i_clk(clk), .i_rst(rst), .bus(bus_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   idx;
        logic         first;
        logic         last;
        logic [127:0] data;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: an accepted word expands into its chunk list; every valid output
    // cycle must show the oldest outstanding chunk of that instance.
    task automatic mon(input int idx, input int dn, input int ow, input bit msb,
                       input logic iv, input logic ordy, input logic [127:0] idata,
                       input logic ov, input logic irdy, input logic [127:0] odata,
                       input logic of, input logic ol);
        int pos;
        int slot;
        exp_t e;
        logic [127:0] mask;
        if (ov) begin
            pos = -1;
            foreach (exp_q[j]) if (pos < 0 && exp_q[j].idx == 2'(idx)) pos = j;
            checks++;
            assert (pos >= 0) else begin
                errors++;
                $error("FAIL sb_unexpected_chunk dut%0d: observed %0h expected none", idx, odata);
            end
            if (pos >= 0) begin
                e = exp_q[pos];
                checks++;
                assert ({of, ol, odata} === {e.first, e.last, e.data}) else begin
                    errors++;
                    $error("FAIL sb_chunk dut%0d: observed f%0b l%0b %0h expected f%0b l%0b %0h",
                           idx, of, ol, odata, e.first, e.last, e.data);
                end
                if (irdy) exp_q.delete(pos);
            end
        end
        if (iv && ordy) begin
            mask = (128'd1 << ow) - 128'd1;
            for (int k = 0; k < dn; k++) begin
                slot    = msb ? (dn - 1 - k) : k;
                e.idx   = 2'(idx);
                e.first = (k == 0);
                e.last  = (k == dn - 1);
                e.data  = (idata >> (slot * ow)) & mask;
                exp_q.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            mon(0, 4, 8,  1'b0, bus_a.i_valid, bus_a.o_ready, 128'(bus_a.i_data), bus_a.o_valid,
                bus_a.i_ready, 128'(bus_a.o_data), bus_a.o_first, bus_a.o_last);
            mon(1, 4, 8,  1'b1, bus_b.i_valid, bus_b.o_ready, 128'(bus_b.i_data), bus_b.o_valid,
                bus_b.i_ready, 128'(bus_b.o_data), bus_b.o_first, bus_b.o_last);
            mon(2, 4, 32, 1'b0, bus_c.i_valid, bus_c.o_ready, bus_c.i_data, bus_c.o_valid,
                bus_c.i_ready, 128'(bus_c.o_data), bus_c.o_first, bus_c.o_last);
            mon(3, 1, 32, 1'b0, bus_d.i_valid, bus_d.o_ready, 128'(bus_d.i_data), bus_d.o_valid,
                bus_d.i_ready, 128'(bus_d.o_data), bus_d.o_first, bus_d.o_last);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] word;
        logic [31:0] word2;
        logic [31:0] expv;
        bit a_acc, c_acc, d_acc;

        rst = 1'b1;
        a_data = '0; a_valid = 1'b0; a_ready = 1'b1;
        c_data = '0; c_valid = 1'b0; c_ready = 1'b1;
        d_data = '0; d_valid = 1'b0; d_ready = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", 128'(bus_a.o_valid), 128'd0);
        chk("reset_data",  128'(bus_a.o_data),  128'd0);
        chk("reset_first", 128'(bus_a.o_first), 128'd0);
        chk("reset_last",  128'(bus_a.o_last),  128'd0);
        chk("reset_ready", 128'(bus_a.o_ready), 128'd1);
        chk("reset_ready_dn1", 128'(bus_d.o_ready), 128'd1);

        // Single word, both chunk orders, latency 1 after accept
        word = 32'h44332211;
        cyc(); a_data = word; a_valid = 1'b1; a_ready = 1'b1;
        @(negedge clk);
        chk("t1_accept_ready", 128'(bus_a.o_ready), 128'd1);
        cyc(); a_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_lsb_data", 128'(bus_a.o_data), 128'((word >> (8*k)) & 32'hFF));
            chk("t2_msb_data", 128'(bus_b.o_data), 128'((word >> (8*(3-k))) & 32'hFF));
            chk("t1_valid", 128'(bus_a.o_valid), 128'd1);
            chk("t1_first", 128'(bus_a.o_first), 128'(k == 0));
            chk("t1_last",  128'(bus_a.o_last),  128'(k == 3));
            cyc();
        end
        @(negedge clk);
        chk("t1_idle_valid", 128'(bus_a.o_valid), 128'd0);

        // Back-to-back words with i_valid held: no bubble
        word  = 32'hDDCCBBAA;
        word2 = 32'h87654321;
        cyc(); a_data = word; a_valid = 1'b1;
        @(negedge clk);
        chk("t3_accept_ready", 128'(bus_a.o_ready), 128'd1);
        cyc(); a_data = word2;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            expv = (k < 4) ? ((word >> (8*k)) & 32'hFF) : ((word2 >> (8*(k-4))) & 32'hFF);
            chk("t3_data",  128'(bus_a.o_data),  128'(expv));
            chk("t3_ready", 128'(bus_a.o_ready), 128'((k % 4) == 3));
            chk("t3_valid", 128'(bus_a.o_valid), 128'd1);
            cyc();
            if (k == 3) a_valid = 1'b0;
        end
        @(negedge clk);
        chk("t3_idle_valid", 128'(bus_a.o_valid), 128'd0);

        // Downstream stall on chunk 2
        word = 32'h44332211;
        cyc(); a_data = word; a_valid = 1'b1;
        cyc(); a_valid = 1'b0;
        @(negedge clk); chk("t4_c0", 128'(bus_a.o_data), 128'h11);
        cyc();
        @(negedge clk); chk("t4_c1", 128'(bus_a.o_data), 128'h22);
        cyc(); a_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_hold_data",  128'(bus_a.o_data),  128'h33);
            chk("t4_hold_valid", 128'(bus_a.o_valid), 128'd1);
            chk("t4_hold_ready", 128'(bus_a.o_ready), 128'd0);
            cyc();
        end
        a_ready = 1'b1;
        @(negedge clk); chk("t4_c2", 128'(bus_a.o_data), 128'h33);
        cyc();
        @(negedge clk); chk("t4_c3", 128'(bus_a.o_data), 128'h44);
        chk("t4_c3_last", 128'(bus_a.o_last), 128'd1);
        cyc();
        @(negedge clk); chk("t4_idle_valid", 128'(bus_a.o_valid), 128'd0);

        // Reset in the middle of a word
        cyc(); a_data = 32'h44332211; a_valid = 1'b1;
        cyc(); a_valid = 1'b0;
        @(negedge clk); chk("t5_c0", 128'(bus_a.o_data), 128'h11);
        cyc(); rst = 1'b1;
        @(negedge clk); chk("t5_c1", 128'(bus_a.o_data), 128'h22);
        cyc(); rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_valid", 128'(bus_a.o_valid), 128'd0);
        chk("t5_rst_data",  128'(bus_a.o_data),  128'd0);
        chk("t5_rst_ready", 128'(bus_a.o_ready), 128'd1);
        chk("t5_rst_first", 128'(bus_a.o_first), 128'd0);
        word = 32'h0000BEEF;
        cyc(); a_data = word; a_valid = 1'b1;
        cyc(); a_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t5_data",  128'(bus_a.o_data),  128'((word >> (8*k)) & 32'hFF));
            chk("t5_first", 128'(bus_a.o_first), 128'(k == 0));
            chk("t5_last",  128'(bus_a.o_last),  128'(k == 3));
            cyc();
        end

        // Random traffic on all instances, upstream holds words until taken
        a_acc = 1'b0; c_acc = 1'b0; d_acc = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!a_valid || a_acc) begin a_valid = ($urandom_range(0, 3) != 0); a_data = $urandom; end
            if (!c_valid || c_acc) begin
                c_valid = ($urandom_range(0, 3) != 0);
                c_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!d_valid || d_acc) begin d_valid = ($urandom_range(0, 1) != 0); d_data = $urandom; end
            a_ready = 1'($urandom_range(0, 1));
            c_ready = 1'($urandom_range(0, 1));
            d_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            a_acc = a_valid && bus_a.o_ready;
            c_acc = c_valid && bus_c.o_ready;
            d_acc = d_valid && bus_d.o_ready;
            cyc();
        end
        a_valid = 1'b0; c_valid = 1'b0; d_valid = 1'b0;
        a_ready = 1'b1; c_ready = 1'b1; d_ready = 1'b1;
        repeat (12) cyc();
        @(negedge clk);
        chk("drain_outstanding", 128'(exp_q.size()), 128'd0);
        chk("drain_valid_c", 128'(bus_c.o_valid), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
